// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: handshake bundle, reset/flush enables and
// the stage payload structs that callers pack into elastic stages.
package pipe_pkg;

    localparam logic FlushEnable = 1'b1;
    localparam logic RstEnable   = 1'b1;

    typedef struct packed {
        logic valid;
        logic ready;
    } stage_hs_t;

    // Example payload carried by the MEM2->WB stage; packed by the caller.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rd_we;
        logic [2:0]  exc_code;
        logic        exc_valid;
    } mem2_wb_t;

endpackage

// File: rtl/stage_slot.sv
// One storage entry of an elastic stage: payload register plus valid bit.
// Clear wins over load; load wins over drop.
module stage_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 128,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic              drop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        vld_d = vld_q;
        if (clr_i)       vld_d = 1'b0;
        else if (ld_i)   vld_d = 1'b1;
        else if (drop_i) vld_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        vld_q <= vld_d;
    end

    // Payload is only touched by clear when zeroing is requested.
    always_ff @(posedge clk) begin
        if (CLEAR_ON_FLUSH && clr_i)
            data_q <= '0;
        else if (ld_i && !clr_i)
            data_q <= data_i;
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/elastic_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, optional
// 2-entry skid (registered up_ready), synchronous flush and hold.
module elastic_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 128,
    parameter bit SKID           = 1'b1,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy
);

    stage_hs_t         up_hs, dn_hs;
    logic              clr, hold_eff;
    logic              up_xfer, dn_xfer;
    logic              base_rdy;
    logic              main_v, main_ld, main_drop;
    logic [DATA_W-1:0] main_din, main_data;
    logic              skid_v;

    assign clr      = (RstEnable & rst) | (FlushEnable & flush);
    assign hold_eff = hold & ~clr;

    assign up_hs.valid = up_valid;
    assign up_hs.ready = base_rdy & ~hold_eff;
    assign dn_hs.valid = main_v & ~hold_eff;
    assign dn_hs.ready = dn_ready;

    // Input offered alongside flush/reset is dropped, a dn transfer still counts.
    assign up_xfer = up_hs.valid & up_hs.ready & ~clr;
    assign dn_xfer = dn_hs.valid & dn_hs.ready;

    stage_slot #(
        .DATA_W        (DATA_W),
        .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)
    ) u_main (
        .clk   (clk),
        .clr_i (clr),
        .ld_i  (main_ld),
        .drop_i(main_drop),
        .data_i(main_din),
        .vld_o (main_v),
        .data_o(main_data)
    );

    generate
        if (SKID) begin : g_skid
            logic              skid_ld, skid_drop;
            logic [DATA_W-1:0] skid_data;

            // up_ready comes straight from the skid valid flop: no comb path from dn_ready.
            assign base_rdy  = ~skid_v;
            assign skid_ld   = up_xfer & main_v & ~dn_xfer;
            assign skid_drop = dn_xfer & skid_v;
            assign main_ld   = (up_xfer & (~main_v | dn_xfer)) | (dn_xfer & skid_v);
            assign main_din  = skid_v ? skid_data : up_data;
            assign main_drop = dn_xfer;

            stage_slot #(
                .DATA_W        (DATA_W),
                .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)
            ) u_skid (
                .clk   (clk),
                .clr_i (clr),
                .ld_i  (skid_ld),
                .drop_i(skid_drop),
                .data_i(up_data),
                .vld_o (skid_v),
                .data_o(skid_data)
            );
        end else begin : g_noskid
            assign skid_v    = 1'b0;
            assign base_rdy  = ~main_v | dn_ready;
            assign main_ld   = up_xfer;
            assign main_din  = up_data;
            assign main_drop = dn_xfer;
        end
    endgenerate

    assign up_ready  = up_hs.ready;
    assign dn_valid  = dn_hs.valid;
    assign dn_data   = main_data;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule
